// File: rtl/inference_sequencer.sv
// inference_sequencer: loads a 14x14 binary image over a valid/ready beat
// interface, evaluates a serial fully-connected output layer against an
// external synchronous weight ROM, and reports the highest-scoring class.
module inference_sequencer #(
  parameter int unsigned N_PIX      = 196,
  parameter int unsigned ROW_BITS   = 7,
  parameter int unsigned N_BEATS    = 28,
  parameter int unsigned N_OUT      = 10,
  parameter int unsigned W_WIDTH    = 8,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [ROW_BITS-1:0]   in_row,
  output logic                  in_ready,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [W_WIDTH-1:0]    w_data,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            digit_out
);

  localparam int unsigned BEAT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int unsigned PIX_W  = (N_PIX > 1)   ? $clog2(N_PIX)   : 1;
  localparam int unsigned NEU_W  = (N_OUT > 1)   ? $clog2(N_OUT)   : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N_BEATS - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(N_PIX - 1);
  localparam logic [NEU_W-1:0]  NEU_LAST  = NEU_W'(N_OUT - 1);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [N_PIX-1:0]             pix_buf_q, pix_buf_d;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic [PIX_W-1:0]             pix_q, pix_d;
  logic [NEU_W-1:0]             neu_q, neu_d;
  logic [ADDR_WIDTH-1:0]        base_q, base_d;
  logic [ADDR_WIDTH-1:0]        last_addr_q, last_addr_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  best_q, best_d;
  logic [NEU_W-1:0]             best_idx_q, best_idx_d;
  // Pixel bit and read-issued flag for the weight that arrives next cycle.
  logic                         pbit_q, pbit_d;
  logic                         pvld_q, pvld_d;

  logic signed [ACC_WIDTH-1:0]  w_ext;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic [ADDR_WIDTH-1:0]        cur_addr;

  assign w_ext    = {{(ACC_WIDTH-W_WIDTH){w_data[W_WIDTH-1]}}, w_data};
  // Running sum including the weight returned this cycle, if it counts.
  assign acc_sum  = (pvld_q && pbit_q) ? (acc_q + w_ext) : acc_q;
  // base_q tracks n*N_PIX so no multiplier is needed for the address.
  assign cur_addr = base_q + ADDR_WIDTH'(pix_q);

  // Moore outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q == S_LOAD);
    busy      = (state_q == S_LOAD) || (state_q == S_COMPUTE) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
    w_rd_en   = (state_q == S_COMPUTE);
    w_addr    = (state_q == S_COMPUTE) ? cur_addr : last_addr_q;
    digit_out = (state_q == S_DONE) ? 4'(best_idx_q) : 4'd0;
  end

  // Next-state and datapath update; abort overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    pix_buf_d   = pix_buf_q;
    beat_d      = beat_q;
    pix_d       = pix_q;
    neu_d       = neu_q;
    base_d      = base_q;
    last_addr_d = last_addr_q;
    acc_d       = acc_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    pbit_d      = 1'b0;
    pvld_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          beat_d  = '0;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          for (int unsigned b = 0; b < N_BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
              pix_buf_d[b*ROW_BITS +: ROW_BITS] = in_row;
            end
          end
          if (beat_q == BEAT_LAST) begin
            state_d    = S_COMPUTE;
            neu_d      = '0;
            pix_d      = '0;
            base_d     = '0;
            acc_d      = '0;
            best_d     = ACC_MIN;
            best_idx_d = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      S_COMPUTE: begin
        pbit_d      = pix_buf_q[pix_q];
        pvld_d      = 1'b1;
        acc_d       = acc_sum;
        last_addr_d = cur_addr;
        if (pix_q == PIX_LAST) begin
          state_d = S_DRAIN;
        end else begin
          pix_d = pix_q + PIX_W'(1);
        end
      end

      S_DRAIN: begin
        // Strict compare keeps the lower index on ties.
        if (acc_sum > best_q) begin
          best_d     = acc_sum;
          best_idx_d = neu_q;
        end
        acc_d = acc_sum;
        if (neu_q == NEU_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COMPUTE;
          neu_d   = neu_q + NEU_W'(1);
          base_d  = base_q + ADDR_WIDTH'(N_PIX);
          pix_d   = '0;
          acc_d   = '0;
        end
      end

      S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          beat_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      pix_buf_d   = '0;
      beat_d      = '0;
      pix_d       = '0;
      neu_d       = '0;
      base_d      = '0;
      last_addr_d = '0;
      acc_d       = '0;
      best_d      = ACC_MIN;
      best_idx_d  = '0;
      pbit_d      = 1'b0;
      pvld_d      = 1'b0;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pix_buf_q   <= '0;
      beat_q      <= '0;
      pix_q       <= '0;
      neu_q       <= '0;
      base_q      <= '0;
      last_addr_q <= '0;
      acc_q       <= '0;
      best_q      <= ACC_MIN;
      best_idx_q  <= '0;
      pbit_q      <= 1'b0;
      pvld_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_buf_q   <= pix_buf_d;
      beat_q      <= beat_d;
      pix_q       <= pix_d;
      neu_q       <= neu_d;
      base_q      <= base_d;
      last_addr_q <= last_addr_d;
      acc_q       <= acc_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      pbit_q      <= pbit_d;
      pvld_q      <= pvld_d;
    end
  end

endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
- Controls the digit-classification datapath.
- Accepts an image as 28 beats of 7 pixels through a valid/ready handshake and stores it in a 196-bit pixel buffer.
- Runs a fully-connected output layer serially, one neuron at a time. Weights are read from an external synchronous weight ROM.
- Tracks the highest-scoring neuron and presents it as a 4-bit BCD digit with a done flag, for the seven-segment/BCD output stage.

Parameters:
- N_PIX, 196, pixels per image (14x14), must equal N_BEATS*ROW_BITS
- ROW_BITS, 7, pixels per input beat
- N_BEATS, 28, input beats per image
- N_OUT, 10, output neurons/classes
- W_WIDTH, 8, signed weight width
- ACC_WIDTH, 16, signed accumulator width, must be >= W_WIDTH+8
- ADDR_WIDTH, 11, weight ROM address width, must satisfy 2^ADDR_WIDTH >= N_OUT*N_PIX

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new image; sampled in IDLE and DONE only
- abort  in  1  synchronous abort; returns to IDLE from any state
- in_valid  in  1  in_row holds a valid beat
- in_row  in  ROW_BITS  pixel beat; bit i = pixel 7k+i of beat k
- in_ready  out  1  high only in LOAD
- w_rd_en  out  1  weight ROM read strobe
- w_addr  out  ADDR_WIDTH  weight address = n*N_PIX + p
- w_data  in  W_WIDTH  signed weight; valid exactly 1 cycle after w_rd_en
- busy  out  1  high in LOAD, COMPUTE, DRAIN
- done  out  1  high in DONE
- digit_out  out  4  winning class index; valid while done=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE
  - all outputs 0: in_ready, w_rd_en, w_addr, busy, done, digit_out
  - pixel buffer, beat counter, pixel counter, neuron counter, accumulator cleared
  - best score = most-negative ACC_WIDTH value
- Reset mid-operation discards all progress; no partial result is ever shown.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE:
  - start=1 -> LOAD, beat counter=0.
- LOAD:
  - in_ready=1.
  - A beat is accepted on a cycle with in_valid&in_ready; it writes buffer[7k+6:7k] and increments k.
  - in_valid gaps are allowed and stall the load.
  - Accepting beat 27 -> COMPUTE with n=0, p=0, acc=0, best=min, best_idx=0.
- COMPUTE:
  - Each cycle: w_rd_en=1, w_addr=n*N_PIX+p, p increments.
  - A 1-cycle delayed copy of p and of the buffer bit drives accumulation: when w_data returns and the delayed pixel bit is 1, acc += sign-extended w_data; otherwise acc is unchanged.
  - Issuing p=N_PIX-1 -> DRAIN.
- DRAIN (1 cycle):
  - w_rd_en=0.
  - Final product is accumulated.
  - Then: if acc_final > best (strict, signed), best=acc_final and best_idx=n. Ties keep the lower index.
  - If n=N_OUT-1 -> DONE; otherwise n++, p=0, acc=0 -> COMPUTE.
- Timing:
  - Each neuron takes N_PIX+1 = 197 cycles; all neurons take 1970 cycles.
  - done rises 1971 cycles after the cycle that accepts beat 27.
- DONE:
  - done=1, digit_out=best_idx; both hold until leaving DONE.
  - start=1 -> LOAD: done drops and digit_out clears to 0 on the next cycle. The buffer is overwritten beat by beat.
- start is ignored in LOAD, COMPUTE and DRAIN.
- abort=1 -> IDLE on the next edge, same clearing as reset. abort has priority over start and over beat acceptance in the same cycle.
- Arithmetic: no overflow is possible with the defaults (|sum| <= 196*128 < 2^15). No saturation logic.
- w_addr holds its last value when w_rd_en=0. The ROM must not be read outside COMPUTE.

Test Plan:
- All-zero image, any ROM contents -> every acc=0, tie resolved to digit_out=0; done rises exactly 1971 cycles after the last beat.
- ROM w(n,p)=n for p=5, else 0; image with only pixel 5 set (beat 0 = 7'b0100000) -> digit_out=9.
- ROM w(n,p)=-n; all-ones image -> scores 0,-196,...; digit_out=0. Also check w_addr runs 0..1959 in order, with one idle cycle after each block of 196.
- Load with in_valid toggling 1-0-1 every cycle -> exactly 28 beats accepted; result matches the gap-free load; in_ready never high outside LOAD.
- Assert abort during COMPUTE at n=4 -> IDLE next cycle, busy=0, done=0. A new start and load produces a correct result.
- Deassert rst_n mid-DRAIN -> all outputs 0 immediately (asynchronously). start in DONE clears done and digit_out the next cycle.
